// File: rtl/store_data_aligner_if.sv
// ----------------------------------------------------------------------------
// store_data_aligner_if
//    Bundles the store-request side and the memory write-beat side of the
//    store-path aligner.
//
//    Parameters
//       DATA_W  beat width in bits (32 or 64)
//       ADDR_W  byte address width
//
//    Signals
//       req_valid / req_ready   store request handshake
//       req_addr                byte address of the store
//       req_data                right-justified store data
//       req_size                0 byte, 1 half, 2 word, 3 dword
//       mem_valid / mem_ready   write beat handshake
//       mem_addr                beat address, low offset bits zero
//       mem_wdata               lane-aligned write data
//       mem_wmask               byte write enables, bit i = lane i
//       mem_last                final beat of the current store
//
//    Modports
//       master  store issuer + memory port (drives requests, consumes beats)
//       slave   the aligner itself
// ----------------------------------------------------------------------------
interface store_data_aligner_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   localparam int NB = DATA_W / 8;

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [1:0]        req_size;

   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [NB-1:0]     mem_wmask;
   logic              mem_last;

   modport master (
      output req_valid, req_addr, req_data, req_size, mem_ready,
      input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask, mem_last
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_size, mem_ready,
      output req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask, mem_last
   );
endinterface

// File: rtl/store_data_aligner.sv
// ----------------------------------------------------------------------------
// store_data_aligner
//    Store-path byte-lane aligner for the memory stage. Accepts a store
//    (address, right-justified data, size) and emits DATA_W-wide write beats
//    with lane-shifted data and a byte write mask. Stores that cross a DATA_W
//    boundary are split into two beats (SPLIT_MISALIGNED=1) or rejected with a
//    one-cycle misalign_err pulse (SPLIT_MISALIGNED=0). Illegal sizes are
//    always rejected. All beat outputs are registered.
//
//    Parameters
//       DATA_W            beat width, 32 or 64
//       ADDR_W            address width
//       SPLIT_MISALIGNED  1: split boundary-crossing stores, 0: reject them
//
//    Ports
//       clk           clock, rising edge
//       rst_n         asynchronous active-low reset
//       bus           store_data_aligner_if.slave (request + beat handshakes)
//       misalign_err  one-cycle pulse for an accepted but rejected store
//       busy          high whenever the FSM is not idle
//
//    State  | Meaning
//    -------+---------------------------------------------------------------
//    IDLE   | no beat pending, ready for a request
//    SEND0  | first (or only) beat presented on mem_*
//    SEND1  | second beat of a split store presented on mem_*
//    ERR    | rejected store, misalign_err high for this one cycle
// ----------------------------------------------------------------------------
module store_data_aligner #(
   parameter int DATA_W           = 32,
   parameter int ADDR_W           = 32,
   parameter int SPLIT_MISALIGNED = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   store_data_aligner_if.slave   bus,
   output logic                  misalign_err,
   output logic                  busy
);

   localparam int NB    = DATA_W / 8;
   localparam int OFS_W = $clog2(NB);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SEND0 = 2'd1;
   localparam logic [1:0] S_SEND1 = 2'd2;
   localparam logic [1:0] S_ERR   = 2'd3;

   logic [1:0]          state;
   logic [1:0]          next_state;

   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [NB-1:0]       wmask_q;
   logic                last_q;
   logic [DATA_W-1:0]   hi_data_q;
   logic [NB-1:0]       hi_mask_q;
   logic                split_q;

   logic [OFS_W-1:0]    off;
   logic [NB-1:0]       lane_en;
   logic [DATA_W-1:0]   data_trunc;
   logic [2*DATA_W-1:0] data2;
   logic [2*NB-1:0]     mask2;
   logic                split_in;
   logic                size_bad;
   logic                reject;
   logic [ADDR_W-1:0]   beat0_addr;

   logic                req_ready_c;
   logic                accept;
   logic                load_new;
   logic                load_hi;

   // ------------------------------------------------------------------
   // Request alignment: bytes of the store are placed into a double-wide
   // window; the low half is beat 0, the high half is the spill-over beat.
   // ------------------------------------------------------------------
   always_comb begin
      off = bus.req_addr[OFS_W-1:0];

      lane_en = '0;
      case (bus.req_size)
         2'd0:    lane_en = NB'(1);
         2'd1:    lane_en = NB'(3);
         2'd2:    lane_en = NB'(15);
         default: lane_en = NB'(255);
      endcase

      // bytes above the store size never reach the write data
      data_trunc = '0;
      for (int i = 0; i < NB; i++) begin
         data_trunc[8*i +: 8] = lane_en[i] ? bus.req_data[8*i +: 8] : 8'h00;
      end

      data2    = {{DATA_W{1'b0}}, data_trunc} << {off, 3'b000};
      mask2    = {{NB{1'b0}}, lane_en} << off;
      split_in = |mask2[2*NB-1:NB];

      // a dword only fits when the beat is 64 bits wide
      size_bad = (bus.req_size == 2'd3) && (DATA_W < 64);
      reject   = size_bad || (split_in && (SPLIT_MISALIGNED == 0));

      beat0_addr = {bus.req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
   end

   // ------------------------------------------------------------------
   // Next state. A request may be accepted on the same cycle the final
   // beat of the previous store hands off, so aligned stores stream at
   // one per cycle.
   // ------------------------------------------------------------------
   always_comb begin
      next_state  = state;
      req_ready_c = 1'b0;
      load_new    = 1'b0;
      load_hi     = 1'b0;

      case (state)
         S_IDLE: begin
            req_ready_c = 1'b1;
         end
         S_SEND0: begin
            if (bus.mem_ready) begin
               if (split_q) begin
                  load_hi    = 1'b1;
                  next_state = S_SEND1;
               end else begin
                  req_ready_c = 1'b1;
                  next_state  = S_IDLE;
               end
            end
         end
         S_SEND1: begin
            if (bus.mem_ready) begin
               req_ready_c = 1'b1;
               next_state  = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase

      accept = bus.req_valid && req_ready_c;
      if (accept) begin
         if (reject) begin
            next_state = S_ERR;
         end else begin
            next_state = S_SEND0;
            load_new   = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // State and beat registers. Reset also drops any stashed second beat.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         last_q    <= 1'b0;
         hi_data_q <= '0;
         hi_mask_q <= '0;
         split_q   <= 1'b0;
      end else begin
         state <= next_state;
         if (load_new) begin
            addr_q    <= beat0_addr;
            wdata_q   <= data2[DATA_W-1:0];
            wmask_q   <= mask2[NB-1:0];
            last_q    <= !split_in;
            hi_data_q <= data2[2*DATA_W-1:DATA_W];
            hi_mask_q <= mask2[2*NB-1:NB];
            split_q   <= split_in;
         end else if (load_hi) begin
            // wraps modulo 2^ADDR_W at the top of the address space
            addr_q    <= addr_q + ADDR_W'(NB);
            wdata_q   <= hi_data_q;
            wmask_q   <= hi_mask_q;
            last_q    <= 1'b1;
            split_q   <= 1'b0;
         end
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.mem_valid = (state == S_SEND0) || (state == S_SEND1);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wmask = wmask_q;
   assign bus.mem_last  = last_q;
   assign misalign_err  = (state == S_ERR);
   assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_store_data_aligner.sv
module tb_store_data_aligner;

   logic        clk;
   logic        rst_n;
   int          sel;
   logic        req_valid;
   logic [31:0] req_addr;
   logic [63:0] req_data;
   logic [1:0]  req_size;
   logic        mem_ready;

   int checks;
   int errors;

   // expected beats for the current store
   bit          exp_err;
   int          exp_n;
   logic [31:0] exp_addr [2];
   logic [63:0] exp_data [2];
   logic [7:0]  exp_mask [2];

   store_data_aligner_if #(.DATA_W(32), .ADDR_W(32)) if_a ();
   store_data_aligner_if #(.DATA_W(32), .ADDR_W(32)) if_b ();
   store_data_aligner_if #(.DATA_W(64), .ADDR_W(32)) if_c ();

   logic err_a, err_b, err_c, busy_a, busy_b, busy_c;

   store_data_aligner #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a), .misalign_err(err_a), .busy(busy_a));
   store_data_aligner #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(0)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b), .misalign_err(err_b), .busy(busy_b));
   store_data_aligner #(.DATA_W(64), .ADDR_W(32), .SPLIT_MISALIGNED(1)) u_c (
      .clk(clk), .rst_n(rst_n), .bus(if_c), .misalign_err(err_c), .busy(busy_c));

   assign if_a.req_valid = req_valid && (sel == 0);
   assign if_a.req_addr  = req_addr;
   assign if_a.req_data  = req_data[31:0];
   assign if_a.req_size  = req_size;
   assign if_a.mem_ready = mem_ready;
   assign if_b.req_valid = req_valid && (sel == 1);
   assign if_b.req_addr  = req_addr;
   assign if_b.req_data  = req_data[31:0];
   assign if_b.req_size  = req_size;
   assign if_b.mem_ready = mem_ready;
   assign if_c.req_valid = req_valid && (sel == 2);
   assign if_c.req_addr  = req_addr;
   assign if_c.req_data  = req_data;
   assign if_c.req_size  = req_size;
   assign if_c.mem_ready = mem_ready;

   logic        o_ready, o_valid, o_last, o_err, o_busy;
   logic [31:0] o_addr;
   logic [63:0] o_wdata;
   logic [7:0]  o_wmask;

   always_comb begin
      o_ready = if_a.req_ready; o_valid = if_a.mem_valid; o_last = if_a.mem_last;
      o_addr  = if_a.mem_addr;  o_wdata = {32'h0, if_a.mem_wdata};
      o_wmask = {4'h0, if_a.mem_wmask}; o_err = err_a; o_busy = busy_a;
      if (sel == 1) begin
         o_ready = if_b.req_ready; o_valid = if_b.mem_valid; o_last = if_b.mem_last;
         o_addr  = if_b.mem_addr;  o_wdata = {32'h0, if_b.mem_wdata};
         o_wmask = {4'h0, if_b.mem_wmask}; o_err = err_b; o_busy = busy_b;
      end else if (sel == 2) begin
         o_ready = if_c.req_ready; o_valid = if_c.mem_valid; o_last = if_c.mem_last;
         o_addr  = if_c.mem_addr;  o_wdata = if_c.mem_wdata;
         o_wmask = if_c.mem_wmask; o_err = err_c; o_busy = busy_c;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: place each store byte at its absolute address, then group
   // bytes by the DW-aligned beat they land in.
   task automatic model(input int dw, input bit split_en, input logic [31:0] addr,
                        input logic [63:0] data, input logic [1:0] size);
      int nbl, nbytes, off, rel, b, l;
      nbl    = dw / 8;
      nbytes = 1 << size;
      off    = int'(addr[2:0]) % nbl;
      exp_err  = 0;
      exp_n    = 1;
      exp_addr[0] = addr - 32'(off);
      exp_addr[1] = exp_addr[0] + 32'(nbl);
      exp_data[0] = '0; exp_data[1] = '0;
      exp_mask[0] = '0; exp_mask[1] = '0;
      if (dw == 32 && size == 2'd3) begin
         exp_err = 1;
         return;
      end
      for (int k = 0; k < nbytes; k++) begin
         rel = off + k;
         b   = rel / nbl;
         l   = rel % nbl;
         exp_data[b][8*l +: 8] = data[8*k +: 8];
         exp_mask[b][l] = 1'b1;
         if (b + 1 > exp_n) exp_n = b + 1;
      end
      if (exp_n == 2 && !split_en) exp_err = 1;
   endtask

   // Issue one store (DUT assumed idle) and check its beats or its error.
   // stall < 0 picks a random stall of 0..2 cycles before each handshake.
   task automatic run_store(input logic [31:0] addr, input logic [63:0] data,
                            input logic [1:0] size, input int stall);
      int st;
      logic [105:0] got, want;
      req_valid = 1'b1; req_addr = addr; req_data = data; req_size = size;
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_ready, o_valid} !== 2'b10) begin
         errors++;
         $display("FAIL accept_idle: ready/valid got %b expected 10", {o_ready, o_valid});
      end
      @(posedge clk); #1;
      req_valid = 1'b0; req_data = {$urandom, $urandom};
      if (exp_err) begin
         @(negedge clk);
         checks++;
         if ({o_err, o_valid, o_ready, o_busy} !== 4'b1001) begin
            errors++;
            $display("FAIL err_pulse: err/valid/ready/busy got %b expected 1001",
                     {o_err, o_valid, o_ready, o_busy});
         end
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if ({o_err, o_valid, o_busy} !== 3'b000) begin
            errors++;
            $display("FAIL err_end: err/valid/busy got %b expected 000", {o_err, o_valid, o_busy});
         end
      end else begin
         for (int b = 0; b < exp_n; b++) begin
            st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            for (int c = 0; c <= st; c++) begin
               mem_ready = (c == st);
               @(negedge clk);
               got  = {o_valid, o_addr, o_wdata, o_wmask, o_last};
               want = {1'b1, exp_addr[b], exp_data[b], exp_mask[b], (b == exp_n - 1)};
               checks++;
               if (got !== want) begin
                  errors++;
                  $display("FAIL beat%0d: valid/addr/data/mask/last got %h expected %h", b, got, want);
               end
               checks++;
               if (o_ready !== (mem_ready && (b == exp_n - 1))) begin
                  errors++;
                  $display("FAIL ready_beat%0d: got %b expected %b", b, o_ready,
                           mem_ready && (b == exp_n - 1));
               end
               @(posedge clk); #1;
            end
         end
         mem_ready = 1'b1;
         @(negedge clk);
         checks++;
         if ({o_valid, o_busy, o_err} !== 3'b000) begin
            errors++;
            $display("FAIL store_end: valid/busy/err got %b expected 000", {o_valid, o_busy, o_err});
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         checks++;
         if ({o_valid, o_addr, o_wdata, o_wmask, o_last, o_err, o_busy, o_ready} !== {106'h0, 3'b001}) begin
            errors++;
            $display("FAIL reset_sel%0d: got %h expected 1", s,
                     {o_valid, o_addr, o_wdata, o_wmask, o_last, o_err, o_busy, o_ready});
         end
      end
      sel = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_byte_half();
      sel = 0;
      exp_err = 0; exp_n = 1;
      exp_addr[0] = 32'h1000; exp_data[0] = 64'hAB000000; exp_mask[0] = 8'h08;
      run_store(32'h1003, 64'hFFFF_FFFF_FFFF_FFAB, 2'd0, 0);
      exp_addr[0] = 32'h2000; exp_data[0] = 64'h12340000; exp_mask[0] = 8'h0C;
      run_store(32'h2002, 64'h0000_1234, 2'd1, 0);
   endtask

   task automatic test_split();
      sel = 0;
      exp_err = 0; exp_n = 2;
      exp_addr[0] = 32'h3000; exp_data[0] = 64'hEF000000; exp_mask[0] = 8'h08;
      exp_addr[1] = 32'h3004; exp_data[1] = 64'h00DEADBE; exp_mask[1] = 8'h07;
      run_store(32'h3003, 64'hDEADBEEF, 2'd2, 0);
   endtask

   task automatic test_backpressure();
      sel = 0;
      exp_err = 0; exp_n = 1;
      exp_addr[0] = 32'h2000; exp_data[0] = 64'h12340000; exp_mask[0] = 8'h0C;
      run_store(32'h2002, 64'h0000_1234, 2'd1, 3);
      exp_n = 2;
      exp_addr[0] = 32'h3000; exp_data[0] = 64'hEF000000; exp_mask[0] = 8'h08;
      exp_addr[1] = 32'h3004; exp_data[1] = 64'h00DEADBE; exp_mask[1] = 8'h07;
      run_store(32'h3003, 64'hDEADBEEF, 2'd2, 3);
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [4];
      logic [105:0] got, want;
      sel = 0;
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      for (int i = 0; i <= 4; i++) begin
         req_valid = (i < 4);
         if (i < 4) begin
            req_addr = 32'(4 * i); req_data = {32'h0, d[i]}; req_size = 2'd2;
         end
         @(negedge clk);
         if (i < 4) begin
            checks++;
            if (o_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_ready%0d: got %b expected 1", i, o_ready);
            end
         end
         if (i > 0) begin
            got  = {o_valid, o_addr, o_wdata, o_wmask, o_last};
            want = {1'b1, 32'(4 * (i - 1)), 32'h0, d[i-1], 8'h0F, 1'b1};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL b2b_beat%0d: got %h expected %h", i - 1, got, want);
            end
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: valid got %b expected 0", o_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_errors();
      sel = 1;
      exp_err = 1; exp_n = 0;
      run_store(32'h0000_0003, 64'h5555, 2'd1, 0);
      sel = 0;
      run_store(32'h0000_0010, 64'h0102030405060708, 2'd3, 0);
      sel = 1;
      exp_err = 0; exp_n = 1;
      exp_addr[0] = 32'h40; exp_data[0] = 64'h00005555; exp_mask[0] = 8'h03;
      run_store(32'h0000_0040, 64'hFFFF_5555, 2'd1, 0);
   endtask

   task automatic test_dw64();
      sel = 2;
      exp_err = 0; exp_n = 2;
      exp_addr[0] = 32'h0; exp_data[0] = 64'h0607080000000000; exp_mask[0] = 8'hE0;
      exp_addr[1] = 32'h8; exp_data[1] = 64'h0000000102030405; exp_mask[1] = 8'h1F;
      run_store(32'h5, 64'h0102030405060708, 2'd3, 1);
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [63:0] dat;
      logic [1:0]  sz;
      int          dw;
      for (int n = 0; n < 60; n++) begin
         sel = int'($urandom_range(0, 2));
         dw  = (sel == 2) ? 64 : 32;
         a   = $urandom;
         if (($urandom % 4) == 0) a = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
         dat = {$urandom, $urandom};
         sz  = 2'($urandom_range(0, 3));
         model(dw, sel != 1, a, dat, sz);
         run_store(a, dat, sz, -1);
      end
   endtask

   task automatic test_reset_mid_send1();
      logic [31:0] d;
      sel = 0;
      d = $urandom;
      model(32, 1'b1, 32'hFFFF_FFFE, {32'h0, d}, 2'd2);
      req_valid = 1'b1; req_addr = 32'hFFFF_FFFE; req_data = {32'h0, d}; req_size = 2'd2;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({o_valid, o_addr, o_wmask, o_last} !== {1'b1, 32'hFFFF_FFFC, exp_mask[0], 1'b0}) begin
         errors++;
         $display("FAIL wrap_beat0: got %h expected %h", {o_valid, o_addr, o_wmask, o_last},
                  {1'b1, 32'hFFFF_FFFC, exp_mask[0], 1'b0});
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({o_valid, o_addr, o_wdata, o_wmask, o_last} !== {1'b1, 32'h0, exp_data[1], exp_mask[1], 1'b1}) begin
         errors++;
         $display("FAIL wrap_beat1: got %h expected %h", {o_valid, o_addr, o_wdata, o_wmask, o_last},
                  {1'b1, 32'h0, exp_data[1], exp_mask[1], 1'b1});
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({o_valid, o_busy, o_addr, o_wdata, o_wmask, o_last, o_err} !== 108'h0) begin
         errors++;
         $display("FAIL async_reset: got %h expected 0",
                  {o_valid, o_busy, o_addr, o_wdata, o_wmask, o_last, o_err});
      end
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if ({o_valid, o_busy, o_ready} !== 3'b001) begin
            errors++;
            $display("FAIL post_reset%0d: valid/busy/ready got %b expected 001", i,
                     {o_valid, o_busy, o_ready});
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      checks = 0; errors = 0;
      sel = 0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
      mem_ready = 1'b1;
      test_reset();
      test_byte_half();
      test_split();
      test_backpressure();
      test_back_to_back();
      test_errors();
      test_dw64();
      test_random();
      test_reset_mid_send1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
